// File: rtl/bcd_serial_alu_ctrl.sv
// rtl/bcd_serial_alu_ctrl.sv - digit-serial multi-digit BCD add/subtract controller
// Optional sign-magnitude fix-up pass enabled by macro BCD_SIGN_MAG_EN.
module bcd_serial_alu_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  op,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   result,
  output logic                  cout,
  output logic                  neg,
  output logic                  bad_digit
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

`ifdef BCD_SIGN_MAG_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_FIX} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
`endif

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  carry_q, carry_d;
  logic                  op_q, op_d;
  logic [4*DIGITS-1:0]   a_q, a_d, b_q, b_d;
  logic [4*DIGITS-1:0]   result_q, result_d;
  logic                  busy_q, busy_d, done_q, done_d;
  logic                  cout_q, cout_d, neg_q, neg_d, bad_q, bad_d;

  logic                  accept, last, in_fix, gt9;
  logic [3:0]            a_sel, b_sel, r_sel, bi, dig;
  logic [4:0]            s;

  function automatic logic any_bad(input logic [4*DIGITS-1:0] v);
    any_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) any_bad = 1'b1;
    end
  endfunction

`ifdef BCD_SIGN_MAG_EN
  assign in_fix = (state_q == S_FIX);
`else
  assign in_fix = 1'b0;
`endif

  assign accept = start && !busy_q;
  assign last   = (idx_q == IW'(DIGITS - 1));

  // Shared single-digit path; the FIX pass feeds 0 - result through it.
  always_comb begin
    a_sel = 4'd0;
    b_sel = 4'd0;
    r_sel = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        a_sel = a_q[4*i +: 4];
        b_sel = b_q[4*i +: 4];
        r_sel = result_q[4*i +: 4];
      end
    end
    if (in_fix) begin
      a_sel = 4'd0;
      b_sel = r_sel;
    end
    bi  = (in_fix || op_q) ? (4'd9 - b_sel) : b_sel;
    s   = {1'b0, a_sel} + {1'b0, bi} + {4'b0000, carry_q};
    gt9 = (s > 5'd9);
    dig = gt9 ? (s[3:0] + 4'd6) : s[3:0];
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cout_d   = cout_q;
    neg_d    = neg_q;
    bad_d    = bad_q;

    case (state_q)
      S_RUN
`ifdef BCD_SIGN_MAG_EN
      , S_FIX
`endif
      : begin
        for (int i = 0; i < DIGITS; i++) begin
          if (idx_q == IW'(i)) result_d[4*i +: 4] = dig;
        end
        carry_d = gt9;
        idx_d   = last ? idx_q : idx_q + IW'(1);
        if (last) begin
`ifdef BCD_SIGN_MAG_EN
          if (state_q == S_RUN && op_q && !gt9) begin
            state_d = S_FIX;
            idx_d   = '0;
            carry_d = 1'b1;
          end else begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            cout_d  = in_fix ? 1'b0 : gt9;
            neg_d   = in_fix;
          end
`else
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cout_d  = gt9;
`endif
        end
      end
      default: begin
        if (accept) begin
          state_d  = S_RUN;
          idx_d    = '0;
          carry_d  = op;
          op_d     = op;
          a_d      = a;
          b_d      = b;
          result_d = '0;
          busy_d   = 1'b1;
          cout_d   = 1'b0;
          neg_d    = 1'b0;
          bad_d    = any_bad(a) || any_bad(b);
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      op_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
      neg_q    <= 1'b0;
      bad_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cout_q   <= cout_d;
      neg_q    <= neg_d;
      bad_q    <= bad_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign cout      = cout_q;
  assign bad_digit = bad_q;
`ifdef BCD_SIGN_MAG_EN
  assign neg       = neg_q;
`else
  assign neg       = 1'b0;
`endif

endmodule
